// File: rtl/gyro_tilt_detector.sv
// Gyro tilt detector: per-axis hysteresis deadband, debounce and sensor watchdog.
// Optional saturation rejection is enabled by defining GYRO_SAT_CHECK_EN.
module gyro_tilt_detector #(
    parameter int DATA_W     = 16,
    parameter int THRESH_ON  = 200,
    parameter int THRESH_OFF = 150,
    parameter int DEBOUNCE   = 4,
    parameter int TIMEOUT    = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] gyro_x_raw,
    input  logic [DATA_W-1:0] gyro_y_raw,
    input  logic [DATA_W-1:0] gyro_z_raw,
    output logic              gyroX,
    output logic              gyro_X,
    output logic              gyroY,
    output logic              gyro_Y,
    output logic              gyroZ,
    output logic              gyro_Z,
    output logic              gyroCheck
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    localparam logic signed [DATA_W:0] ON_P  = (DATA_W+1)'(THRESH_ON);
    localparam logic signed [DATA_W:0] ON_N  = (DATA_W+1)'(-THRESH_ON);
    localparam logic signed [DATA_W:0] OFF_P = (DATA_W+1)'(THRESH_OFF);
    localparam logic signed [DATA_W:0] OFF_N = (DATA_W+1)'(-THRESH_OFF);
    localparam logic [CW-1:0]          DB    = CW'(DEBOUNCE);
    localparam logic [WW-1:0]          TO    = WW'(TIMEOUT);

    typedef enum logic [1:0] {
        NEUTRAL = 2'd0,
        POS     = 2'd1,
        NEG     = 2'd2
    } axis_t;

    axis_t                  st    [3];
    axis_t                  st_n  [3];
    logic [CW-1:0]          cnt   [3];
    logic [CW-1:0]          cnt_n [3];
    logic [CW-1:0]          c1    [3];
    logic                   dir   [3];
    logic                   dir_n [3];
    logic signed [DATA_W:0] smp   [3];
    logic [WW-1:0]          wd;
    logic [WW-1:0]          wd_n;
    logic                   sat;
    logic                   upd;
    logic                   timeout;

    // Sign-extend so negated thresholds and the most-negative code compare safely
    assign smp[0] = {gyro_x_raw[DATA_W-1], gyro_x_raw};
    assign smp[1] = {gyro_y_raw[DATA_W-1], gyro_y_raw};
    assign smp[2] = {gyro_z_raw[DATA_W-1], gyro_z_raw};

`ifdef GYRO_SAT_CHECK_EN
    localparam logic [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

    function automatic logic is_ext(input logic [DATA_W-1:0] v);
        return (v == SMAX) || (v == SMIN);
    endfunction

    assign sat = is_ext(gyro_x_raw) | is_ext(gyro_y_raw) | is_ext(gyro_z_raw);
`else
    assign sat = 1'b0;
`endif

    assign upd = sample_valid && !sat;

    always_comb begin
        if (sample_valid)
            wd_n = '0;
        else if (wd == TO)
            wd_n = TO;
        else
            wd_n = wd + WW'(1);
    end

    assign timeout = !sample_valid && (wd_n == TO);

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            st_n[i]  = st[i];
            cnt_n[i] = cnt[i];
            dir_n[i] = dir[i];
            c1[i]    = '0;
            if (timeout) begin
                st_n[i]  = NEUTRAL;
                cnt_n[i] = '0;
            end else if (upd) begin
                case (st[i])
                    NEUTRAL: begin
                        if (smp[i] > ON_P || smp[i] < ON_N) begin
                            // dir=1 tracks the negative direction
                            c1[i] = (dir[i] == (smp[i] < ON_N)) ?
                                    cnt[i] + CW'(1) : CW'(1);
                            dir_n[i] = (smp[i] < ON_N);
                            if (c1[i] == DB) begin
                                st_n[i]  = (smp[i] < ON_N) ? NEG : POS;
                                cnt_n[i] = '0;
                            end else begin
                                cnt_n[i] = c1[i];
                            end
                        end else begin
                            cnt_n[i] = '0;
                        end
                    end
                    POS: begin
                        if (smp[i] < OFF_P) begin
                            c1[i] = cnt[i] + CW'(1);
                            if (c1[i] == DB) begin
                                st_n[i]  = NEUTRAL;
                                cnt_n[i] = '0;
                            end else begin
                                cnt_n[i] = c1[i];
                            end
                        end else begin
                            cnt_n[i] = '0;
                        end
                    end
                    NEG: begin
                        if (smp[i] > OFF_N) begin
                            c1[i] = cnt[i] + CW'(1);
                            if (c1[i] == DB) begin
                                st_n[i]  = NEUTRAL;
                                cnt_n[i] = '0;
                            end else begin
                                cnt_n[i] = c1[i];
                            end
                        end else begin
                            cnt_n[i] = '0;
                        end
                    end
                    default: begin
                        st_n[i]  = NEUTRAL;
                        cnt_n[i] = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                st[i]  <= NEUTRAL;
                cnt[i] <= '0;
                dir[i] <= 1'b0;
            end
            wd        <= '0;
            gyroCheck <= 1'b0;
            gyroX     <= 1'b0;
            gyro_X    <= 1'b0;
            gyroY     <= 1'b0;
            gyro_Y    <= 1'b0;
            gyroZ     <= 1'b0;
            gyro_Z    <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                st[i]  <= st_n[i];
                cnt[i] <= cnt_n[i];
                dir[i] <= dir_n[i];
            end
            wd <= wd_n;
            if (sample_valid)
                gyroCheck <= !sat;
            else if (timeout)
                gyroCheck <= 1'b0;
            gyroX  <= (st_n[0] == POS);
            gyro_X <= (st_n[0] == NEG);
            gyroY  <= (st_n[1] == POS);
            gyro_Y <= (st_n[1] == NEG);
            gyroZ  <= (st_n[2] == POS);
            gyro_Z <= (st_n[2] == NEG);
        end
    end

endmodule

// File: tb/tb_gyro_tilt_detector.sv
// Self-checking bench for gyro_tilt_detector: directed scenarios plus
// randomized samples against a behavioural model of the tilt/debounce rules.
module tb_gyro_tilt_detector;

    localparam int DATA_W = 16;
    localparam int ON     = 200;
    localparam int OFF    = 150;
    localparam int DB     = 4;
    localparam int TO     = 1000;
    localparam int MAXV   = 32767;
    localparam int MINV   = -32768;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              sample_valid = 1'b0;
    logic [DATA_W-1:0] gyro_x_raw = '0;
    logic [DATA_W-1:0] gyro_y_raw = '0;
    logic [DATA_W-1:0] gyro_z_raw = '0;
    logic gyroX, gyro_X, gyroY, gyro_Y, gyroZ, gyro_Z, gyroCheck;

    int checks = 0;
    int errors = 0;

    // Model: tilt per axis (+1/0/-1), run length and run direction
    int  m_tilt [3];
    int  m_run  [3];
    int  m_rdir [3];
    int  m_idle;
    bit  m_chk;

    gyro_tilt_detector #(
        .DATA_W(DATA_W), .THRESH_ON(ON), .THRESH_OFF(OFF),
        .DEBOUNCE(DB), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .sample_valid(sample_valid),
        .gyro_x_raw(gyro_x_raw), .gyro_y_raw(gyro_y_raw),
        .gyro_z_raw(gyro_z_raw),
        .gyroX(gyroX), .gyro_X(gyro_X), .gyroY(gyroY), .gyro_Y(gyro_Y),
        .gyroZ(gyroZ), .gyro_Z(gyro_Z), .gyroCheck(gyroCheck)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] obs();
        return {gyroX, gyro_X, gyroY, gyro_Y, gyroZ, gyro_Z, gyroCheck};
    endfunction

    function automatic logic [6:0] exp_vec();
        return {m_tilt[0] == 1, m_tilt[0] == -1, m_tilt[1] == 1,
                m_tilt[1] == -1, m_tilt[2] == 1, m_tilt[2] == -1, m_chk};
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 3; i++) begin
            m_tilt[i] = 0; m_run[i] = 0; m_rdir[i] = 0;
        end
        m_idle = 0;
        m_chk  = 0;
    endfunction

    // One valid sample on one axis, from the tilt rules
    function automatic void model_axis(int i, int s);
        int want;
        if (m_tilt[i] == 0) begin
            want = (s > ON) ? 1 : (s < -ON) ? -1 : 0;
            if (want == 0) begin
                m_run[i] = 0;
            end else begin
                if (m_run[i] > 0 && m_rdir[i] == want) m_run[i]++;
                else m_run[i] = 1;
                m_rdir[i] = want;
                if (m_run[i] == DB) begin
                    m_tilt[i] = want; m_run[i] = 0;
                end
            end
        end else begin
            if ((m_tilt[i] == 1 && s < OFF) || (m_tilt[i] == -1 && s > -OFF))
                m_run[i]++;
            else
                m_run[i] = 0;
            if (m_run[i] == DB) begin
                m_tilt[i] = 0; m_run[i] = 0;
            end
        end
    endfunction

    function automatic void model_step(bit v, int x, int y, int z);
        bit sat = 0;
`ifdef GYRO_SAT_CHECK_EN
        sat = (x == MAXV || x == MINV || y == MAXV || y == MINV ||
               z == MAXV || z == MINV);
`endif
        if (v) begin
            m_idle = 0;
            m_chk  = !sat;
            if (!sat) begin
                model_axis(0, x); model_axis(1, y); model_axis(2, z);
            end
        end else begin
            if (m_idle < TO) m_idle++;
            if (m_idle == TO) begin
                m_chk = 0;
                for (int i = 0; i < 3; i++) begin
                    m_tilt[i] = 0; m_run[i] = 0;
                end
            end
        end
    endfunction

    task automatic cyc(input bit v, input int x, input int y, input int z);
        sample_valid = v;
        gyro_x_raw = x[DATA_W-1:0];
        gyro_y_raw = y[DATA_W-1:0];
        gyro_z_raw = z[DATA_W-1:0];
        @(posedge clk);
        model_step(v, x, y, z);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sample_valid = 1'b1;
        gyro_x_raw = 16'd300;
        gyro_y_raw = 16'd300;
        gyro_z_raw = 16'd300;
        @(posedge clk);
        model_clear();
        #1;
        reset = 1'b0;
        sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs() !== 7'b0) begin
            errors++;
            $display("FAIL reset_state got %b want %b", obs(), 7'b0);
        end
        for (int k = 0; k < DB; k++) cyc(1, 300, 0, 0);
        do_reset();
        checks++;
        if (obs() !== 7'b0) begin
            errors++;
            $display("FAIL reset_from_pos got %b want %b", obs(), 7'b0);
        end
    endtask

    task automatic test_debounce_pos();
        do_reset();
        cyc(1, 300, 0, 0);
        checks++;
        if (gyroCheck !== 1'b1 || gyroX !== 1'b0) begin
            errors++;
            $display("FAIL first_sample got chk=%b x=%b want chk=1 x=0",
                     gyroCheck, gyroX);
        end
        cyc(1, 300, 0, 0);
        cyc(1, 300, 0, 0);
        checks++;
        if (gyroX !== 1'b0) begin
            errors++;
            $display("FAIL third_sample got %b want 0", gyroX);
        end
        cyc(1, 300, 0, 0);
        checks++;
        if ({gyroX, gyro_X} !== 2'b10) begin
            errors++;
            $display("FAIL fourth_sample got %b want 10", {gyroX, gyro_X});
        end
    endtask

    task automatic test_counter_clear();
        do_reset();
        cyc(1, 300, 0, 0); cyc(1, 300, 0, 0); cyc(1, 300, 0, 0);
        cyc(1, 100, 0, 0); cyc(1, 300, 0, 0);
        cyc(1, 300, 0, 0); cyc(1, 300, 0, 0);
        checks++;
        if (gyroX !== 1'b0) begin
            errors++;
            $display("FAIL clear_run got %b want 0", gyroX);
        end
        cyc(1, 300, 0, 0);
        checks++;
        if (gyroX !== 1'b1) begin
            errors++;
            $display("FAIL clear_rerun got %b want 1", gyroX);
        end
        cyc(1, 300, 0, 0);
        do_reset();
        for (int k = 0; k < 6; k++) cyc(1, 200, -200, 0);
        checks++;
        if (obs() !== 7'b0000001) begin
            errors++;
            $display("FAIL thresh_equal got %b want %b", obs(), 7'b0000001);
        end
        for (int k = 0; k < DB; k++) cyc(1, 201, -201, 0);
        checks++;
        if (obs() !== 7'b1001001) begin
            errors++;
            $display("FAIL thresh_plus1 got %b want %b", obs(), 7'b1001001);
        end
    endtask

    task automatic test_hysteresis();
        do_reset();
        for (int k = 0; k < DB; k++) cyc(1, 300, 0, 0);
        for (int k = 0; k < 10; k++) cyc(1, 170, 0, 0);
        for (int k = 0; k < 6; k++) cyc(1, 150, 0, 0);
        checks++;
        if (gyroX !== 1'b1) begin
            errors++;
            $display("FAIL hyst_hold got %b want 1", gyroX);
        end
        for (int k = 0; k < DB - 1; k++) cyc(1, 149, 0, 0);
        checks++;
        if (gyroX !== 1'b1) begin
            errors++;
            $display("FAIL hyst_early got %b want 1", gyroX);
        end
        cyc(1, 149, 0, 0);
        checks++;
        if (gyroX !== 1'b0) begin
            errors++;
            $display("FAIL hyst_release got %b want 0", gyroX);
        end
    endtask

    task automatic test_reversal();
        do_reset();
        for (int k = 0; k < DB + 2; k++) cyc(1, 0, -250, 0);
        checks++;
        if ({gyroY, gyro_Y} !== 2'b01) begin
            errors++;
            $display("FAIL rev_neg got %b want 01", {gyroY, gyro_Y});
        end
        for (int k = 0; k < DB; k++) cyc(1, 0, 300, 0);
        checks++;
        if ({gyroY, gyro_Y} !== 2'b00) begin
            errors++;
            $display("FAIL rev_neutral got %b want 00", {gyroY, gyro_Y});
        end
        for (int k = 0; k < DB; k++) cyc(1, 0, 300, 0);
        checks++;
        if (obs() !== 7'b0010001) begin
            errors++;
            $display("FAIL rev_pos got %b want %b", obs(), 7'b0010001);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int k = 0; k < DB; k++) cyc(1, 300, 0, 0);
        for (int k = 0; k < TO - 1; k++) cyc(0, 0, 0, 0);
        checks++;
        if ({gyroX, gyroCheck} !== 2'b11) begin
            errors++;
            $display("FAIL to_before got %b want 11", {gyroX, gyroCheck});
        end
        cyc(1, 300, 0, 0);
        checks++;
        if ({gyroX, gyroCheck} !== 2'b11) begin
            errors++;
            $display("FAIL to_priority got %b want 11", {gyroX, gyroCheck});
        end
        for (int k = 0; k < TO; k++) cyc(0, 0, 0, 0);
        checks++;
        if ({gyroX, gyroCheck} !== 2'b00) begin
            errors++;
            $display("FAIL to_expire got %b want 00", {gyroX, gyroCheck});
        end
        cyc(1, 0, 0, 0);
        checks++;
        if (obs() !== 7'b0000001) begin
            errors++;
            $display("FAIL to_recover got %b want %b", obs(), 7'b0000001);
        end
    endtask

    task automatic test_sat();
        do_reset();
        for (int k = 0; k < DB; k++) cyc(1, 0, 0, -300);
        cyc(1, 0, 0, MAXV);
`ifdef GYRO_SAT_CHECK_EN
        checks++;
        if ({gyroZ, gyro_Z, gyroCheck} !== 3'b010) begin
            errors++;
            $display("FAIL sat_reject got %b want 010",
                     {gyroZ, gyro_Z, gyroCheck});
        end
        cyc(1, 0, 0, 0);
        checks++;
        if ({gyro_Z, gyroCheck} !== 2'b11) begin
            errors++;
            $display("FAIL sat_recover got %b want 11", {gyro_Z, gyroCheck});
        end
`else
        for (int k = 0; k < DB - 1; k++) cyc(1, 0, 0, MAXV);
        checks++;
        if ({gyroZ, gyro_Z, gyroCheck} !== 3'b001) begin
            errors++;
            $display("FAIL sat_plain got %b want 001",
                     {gyroZ, gyro_Z, gyroCheck});
        end
        for (int k = 0; k < DB; k++) cyc(1, 0, 0, MINV);
        checks++;
        if ({gyroZ, gyro_Z, gyroCheck} !== 3'b011) begin
            errors++;
            $display("FAIL sat_minneg got %b want 011",
                     {gyroZ, gyro_Z, gyroCheck});
        end
`endif
    endtask

    task automatic test_random();
        int vals [16] = '{0, 149, -149, 150, -150, 151, -151, 199, -199,
                          200, -200, 201, -201, 300, MAXV, MINV};
        int x, y, z, run;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            x = vals[$urandom_range(0, 15)];
            y = vals[$urandom_range(0, 15)];
            z = vals[$urandom_range(0, 15)];
            run = $urandom_range(1, 6);
            for (int k = 0; k < run; k++) begin
                cyc($urandom_range(0, 9) != 0, x, y, z);
                checks++;
                if (obs() !== exp_vec()) begin
                    errors++;
                    $display("FAIL random n=%0d got %b want %b",
                             n, obs(), exp_vec());
                end
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_debounce_pos();
        test_counter_clear();
        test_hysteresis();
        test_reversal();
        test_timeout();
        test_sat();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
